// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues data-memory accesses over a req/ack bus,
// stalls the front end while busy, and registers the write-back fields.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic        jal,
    input  logic        jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rd_idx,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic [31:0] alu_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        m2r_q;

    logic        mem_op;
    logic        mis;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign mem_op = ex_valid & (mem_read | mem_write);

    always_comb begin
        mis = 1'b0;
        if (funct3[1:0] == 2'b01)
            mis = alu_result[0];
        else if (funct3[1:0] == 2'b10)
            mis = |alu_result[1:0];
    end

    always_comb begin
        if (state == BUSY)
            stall = ~dmem_ack;
        else
            stall = mem_op & ~mis;
    end

    // Loads enable all lanes; the load extractor picks the bytes it needs.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = store_data;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << alu_result[1:0];
                    wdata_n = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << alu_result[1:0];
                    wdata_n = {2{store_data[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = store_data;
                end
            endcase
        end
    end

    always_comb begin
        shifted = dmem_rdata >> {alu_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misaligned   <= 1'b0;
            alu_q        <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            m2r_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid     <= 1'b0;
                    wb_reg_write <= 1'b0;
                    misaligned   <= 1'b0;
                    if (ex_valid && !(mem_read || mem_write)) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_idx;
                        wb_reg_write <= reg_write;
                        wb_data      <= (jal || jalr) ? pc_plus4 : alu_result;
                    end else if (mem_op && mis) begin
                        misaligned <= 1'b1;
                    end else if (mem_op) begin
                        state      <= BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {alu_result[31:2], 2'b00};
                        dmem_be    <= be_n;
                        dmem_wdata <= wdata_n;
                        alu_q      <= alu_result;
                        f3_q       <= funct3;
                        rd_q       <= rd_idx;
                        rw_q       <= reg_write;
                        m2r_q      <= mem_to_reg;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_reg_write <= rw_q & ~dmem_we;
                        wb_data      <= (!dmem_we && m2r_q) ? load_val : alu_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected write-backs are queued at issue
// and compared when wb_valid appears; bus fields and stall are checked inline.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, mem_read, mem_write, mem_to_reg, reg_write, jal, jalr;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data, pc_plus4;
    logic [4:0]  rd_idx;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .jal(jal), .jalr(jalr), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .pc_plus4(pc_plus4), .rd_idx(rd_idx),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk_data;
        int          cyc;
    } wb_t;

    wb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_spurious", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                if (e.chk_data) check("wb_data", wb_data, e.data);
                check("wb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle_inputs();
        ex_valid = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
        jal = 0; jalr = 0; funct3 = 3'b000; alu_result = '0; store_data = '0;
        pc_plus4 = '0; rd_idx = '0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] pc, input logic jl, input logic jr);
        wb_t e;
        idle_inputs();
        ex_valid = 1; reg_write = 1; jal = jl; jalr = jr;
        alu_result = alu; pc_plus4 = pc; rd_idx = rd;
        e.rd = rd; e.rw = 1'b1; e.data = (jl || jr) ? pc : alu; e.chk_data = 1'b1; e.cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        check("alu_stall", {31'd0, stall}, 32'd0);
        check("alu_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic mem_access(input logic rd_en, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input logic [31:0] rdata, input logic m2r,
                              input logic [4:0] rd, input int wait_n);
        wb_t         e;
        logic [31:0] sh, exp_ld, exp_wd;
        logic [3:0]  exp_be;
        int          stalls;
        sh = rdata >> (int'(addr[1:0]) * 8);
        case (f3)
            3'b000:  exp_ld = {{24{sh[7]}}, sh[7:0]};
            3'b001:  exp_ld = {{16{sh[15]}}, sh[15:0]};
            3'b100:  exp_ld = {24'd0, sh[7:0]};
            3'b101:  exp_ld = {16'd0, sh[15:0]};
            default: exp_ld = rdata;
        endcase
        exp_be = 4'b1111;
        exp_wd = sd;
        if (wr && f3[1:0] == 2'b00) begin exp_be = 4'b0001 << addr[1:0]; exp_wd = {4{sd[7:0]}}; end
        if (wr && f3[1:0] == 2'b01) begin exp_be = 4'b0011 << addr[1:0]; exp_wd = {2{sd[15:0]}}; end
        idle_inputs();
        ex_valid = 1; mem_read = rd_en; mem_write = wr; mem_to_reg = m2r; reg_write = 1;
        funct3 = f3; alu_result = addr; store_data = sd; rd_idx = rd;
        e.rd = rd; e.rw = ~wr; e.data = m2r ? exp_ld : addr; e.chk_data = ~wr;
        e.cyc = cyc + 2 + wait_n;
        sb.push_back(e);
        stalls = 0;
        @(negedge clk);
        check("mem_stall0", {31'd0, stall}, 32'd1);
        check("mem_req0", {31'd0, dmem_req}, 32'd0);
        if (stall) stalls++;
        @(posedge clk); #1;
        for (int w = 0; w <= wait_n; w++) begin
            if (w == wait_n) begin dmem_ack = 1; dmem_rdata = rdata; end
            else dmem_rdata = $urandom;
            @(negedge clk);
            check("bus_req", {31'd0, dmem_req}, 32'd1);
            check("bus_we", {31'd0, dmem_we}, {31'd0, wr});
            check("bus_addr", dmem_addr, {addr[31:2], 2'b00});
            check("bus_be", {28'd0, dmem_be}, {28'd0, exp_be});
            if (wr) check("bus_wdata", dmem_wdata, exp_wd);
            if (stall) stalls++;
            @(posedge clk); #1;
            dmem_ack = 0;
        end
        check("stall_len", stalls, wait_n + 1);
        idle_inputs();
    endtask

    task automatic misaligned_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        idle_inputs();
        ex_valid = 1; mem_read = ~wr; mem_write = wr; mem_to_reg = 1; reg_write = 1;
        funct3 = f3; alu_result = addr; rd_idx = 5'd9;
        @(negedge clk);
        check("mis_stall", {31'd0, stall}, 32'd0);
        check("mis_req0", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        check("mis_req1", {31'd0, dmem_req}, 32'd0);
        check("mis_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_single", {31'd0, misaligned}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        dmem_ack = 0;
        dmem_rdata = '0;
        #2;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        alu_op(5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            alu_op(5'($urandom_range(1, 31)), $urandom, $urandom, 1'b0, 1'b0);
        alu_op(5'd1, 32'h0000_0ABC, 32'h0000_0044, 1'b1, 1'b0);
        alu_op(5'd2, 32'h0000_0DEF, 32'h0000_0088, 1'b0, 1'b1);

        mem_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1, 5'd6, 2);
        mem_access(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 0, 5'd7, 3);
        mem_access(1, 0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_F678, 1, 5'd8, 1);
        mem_access(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 1, 5'd10, 0);
        mem_access(1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h0000_9ABC, 1, 5'd11, 0);
        mem_access(1, 0, 3'b010, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1, 5'd12, 0);
        mem_access(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 0, 5'd13, 1);
        mem_access(0, 1, 3'b000, 32'h0000_0601, 32'h1234_5678, 32'h0, 0, 5'd14, 0);
        mem_access(1, 1, 3'b010, 32'h0000_0700, 32'hCAFE_F00D, 32'h0, 0, 5'd15, 1);
        alu_op(5'd3, 32'h0000_0777, 32'h0, 1'b0, 1'b0);

        misaligned_op(0, 3'b010, 32'h0000_0101);
        misaligned_op(0, 3'b001, 32'h0000_0103);
        misaligned_op(1, 3'b010, 32'h0000_0202);

        // Abort a load mid-access with reset, then present a stray ack.
        idle_inputs();
        ex_valid = 1; mem_read = 1; mem_to_reg = 1; reg_write = 1;
        funct3 = 3'b010; alu_result = 32'h0000_0300; rd_idx = 5'd20;
        @(posedge clk); #1;
        check("abort_req_before", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("abort_req", {31'd0, dmem_req}, 32'd0);
        check("abort_addr", dmem_addr, 32'd0);
        check("abort_we", {31'd0, dmem_we}, 32'd0);
        check("abort_wdata", dmem_wdata, 32'd0);
        check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("abort_stall_eq", {31'd0, stall}, 32'd1);
        idle_inputs();
        #1;
        check("abort_stall_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        dmem_ack = 1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("stray_ack_req", {31'd0, dmem_req}, 32'd0);
        check("stray_ack_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk);
        check("stray_ack_wb", {31'd0, wb_valid}, 32'd0);
        check("stray_ack_req2", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;

        mem_access(1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 1, 5'd21, 1);
        @(negedge clk);
        check("no_reissue", {31'd0, dmem_req}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
